// File: rtl/axil_cfg_loader_if.sv
// AXI-Lite configuration bus: 32-bit address, 64-bit data.
// The slave modport faces the config-register block; the master modport
// faces whatever drives it (host bridge or testbench).
interface axil_cfg_loader_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
               arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
               arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_cfg_loader.sv
// axil_cfg_loader: AXI-Lite configuration registers plus a program-load
// beat stager. The host fills a LOAD_DATA_W-wide staging buffer 64 bits at
// a time, then commits it as a single AW/W beat on the load port.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   axil                   AXI-Lite slave (32b address, 64b data)
//   enable                 core bus enable
//   physical_address_base  host base address
//   core_rst               core soft reset
//   load_en                RAM reload mode
//   load_aw_*              load address channel (byte address, wraps)
//   load_w_*               load data channel (staged beat, all-ones strobe)
module axil_cfg_loader #(
    parameter int LOAD_DATA_W = 512,
    parameter int LOAD_ADDR_W = 15
) (
    input  logic                     clk,
    input  logic                     rstn,
    axil_cfg_loader_if.slave         axil,
    output logic                     enable,
    output logic [63:0]              physical_address_base,
    output logic                     core_rst,
    output logic                     load_en,
    output logic                     load_aw_valid,
    input  logic                     load_aw_ready,
    output logic [LOAD_ADDR_W-1:0]   load_aw_addr,
    output logic                     load_w_valid,
    input  logic                     load_w_ready,
    output logic [LOAD_DATA_W-1:0]   load_w_data,
    output logic [LOAD_DATA_W/8-1:0] load_w_strb
);
    localparam int LANES = LOAD_DATA_W / 64;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0]       LAST_LANE = IDX_W'(LANES - 1);
    localparam logic [LOAD_ADDR_W-1:0] AW_STEP   = LOAD_ADDR_W'(LOAD_DATA_W / 8);
    localparam logic [63:0]            ID_WORD   = 64'hA0A1A2A3_DEADBEEF;
    localparam logic [63:0]            BAD_WORD  = 64'hDEADDEAD_DEADDEAD;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE_W, ST_WRITE_B} state_t;

    state_t                 state;
    logic [31:0]            wr_addr;
    logic [IDX_W-1:0]       lane_idx;
    logic [31:0]            beat_count;
    logic                   err;
    logic [63:0]            rd_mux;

    logic wr_fire, wr_enable, wr_base, wr_core_rst, wr_load_en, wr_lane_idx;
    logic wr_lane_data, wr_commit, wr_err_clr, wr_aw_addr;
    logic aw_hs, w_hs, commit_ok, err_set;

    assign axil.awready = (state == ST_IDLE);
    assign axil.arready = (state == ST_IDLE);
    assign axil.wready  = (state == ST_WRITE_W);
    assign axil.rvalid  = (state == ST_READ);
    assign axil.bvalid  = (state == ST_WRITE_B);
    assign axil.bresp   = 2'b00;
    assign axil.rresp   = 2'b00;

    assign load_w_strb  = '1;

    // A register write takes effect on the WRITE_W/wvalid cycle edge.
    assign wr_fire      = (state == ST_WRITE_W) && axil.wvalid;
    assign wr_enable    = wr_fire && (wr_addr == 32'h10);
    assign wr_base      = wr_fire && (wr_addr == 32'h20);
    assign wr_core_rst  = wr_fire && (wr_addr == 32'h30);
    assign wr_load_en   = wr_fire && (wr_addr == 32'h50);
    assign wr_lane_idx  = wr_fire && (wr_addr == 32'h60);
    assign wr_lane_data = wr_fire && (wr_addr == 32'h70);
    assign wr_commit    = wr_fire && (wr_addr == 32'h80);
    assign wr_err_clr   = wr_fire && (wr_addr == 32'h90);
    assign wr_aw_addr   = wr_fire && (wr_addr == 32'hA0);

    assign aw_hs     = load_aw_valid && load_aw_ready;
    assign w_hs      = load_w_valid && load_w_ready;
    // Commit only starts a beat when the previous one has fully drained.
    assign commit_ok = wr_commit && load_en && !load_aw_valid && !load_w_valid;
    // Staging edits while a beat is offered would corrupt load_w_data.
    assign err_set   = (wr_commit && !commit_ok)
                     || ((wr_lane_data || wr_lane_idx) && load_w_valid);

    always_comb begin
        rd_mux = BAD_WORD;
        case (axil.araddr)
            32'h00: rd_mux = ID_WORD;
            32'h10: rd_mux = {63'd0, enable};
            32'h20: rd_mux = physical_address_base;
            32'h30: rd_mux = {63'd0, core_rst};
            32'h50: rd_mux = {63'd0, load_en};
            32'h60: rd_mux = {{(64-IDX_W){1'b0}}, lane_idx};
            32'h70, 32'h80, 32'h90: rd_mux = 64'd0;
            32'h88: rd_mux = {beat_count, 29'd0, err, load_aw_valid, load_w_valid};
            32'hA0: rd_mux = {{(64-LOAD_ADDR_W){1'b0}}, load_aw_addr};
            default: rd_mux = BAD_WORD;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            wr_addr    <= '0;
            axil.rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    axil.rdata <= rd_mux;
                    if (axil.awvalid) begin
                        wr_addr <= axil.awaddr;
                        state   <= ST_WRITE_W;
                    end else if (axil.arvalid) begin
                        state   <= ST_READ;
                    end
                end
                ST_READ:    if (axil.rready) state <= ST_IDLE;
                ST_WRITE_W: if (axil.wvalid) state <= ST_WRITE_B;
                ST_WRITE_B: if (axil.bready) state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            enable                <= 1'b0;
            physical_address_base <= '0;
            core_rst              <= 1'b0;
            load_en               <= 1'b0;
            load_aw_valid         <= 1'b0;
            load_w_valid          <= 1'b0;
            load_aw_addr          <= '0;
            load_w_data           <= '0;
            lane_idx              <= '0;
            beat_count            <= '0;
            err                   <= 1'b0;
        end else begin
            if (wr_enable)   enable                <= axil.wdata[0];
            if (wr_base)     physical_address_base <= axil.wdata;
            if (wr_core_rst) core_rst              <= axil.wdata[0];
            if (wr_load_en)  load_en               <= axil.wdata[0];

            if (wr_lane_data && !load_w_valid) begin
                for (int k = 0; k < LANES; k++) begin
                    if (lane_idx == IDX_W'(k)) begin
                        for (int b = 0; b < 8; b++) begin
                            if (axil.wstrb[b])
                                load_w_data[k*64 + b*8 +: 8] <= axil.wdata[b*8 +: 8];
                        end
                    end
                end
                lane_idx <= (lane_idx == LAST_LANE) ? '0 : lane_idx + IDX_W'(1);
            end else if (wr_lane_idx && !load_w_valid) begin
                lane_idx <= axil.wdata[IDX_W-1:0];
            end

            // Valids never clear on the commit cycle: commit_ok needs both low.
            if (commit_ok) begin
                load_aw_valid <= 1'b1;
                load_w_valid  <= 1'b1;
            end else begin
                if (aw_hs) load_aw_valid <= 1'b0;
                if (w_hs)  load_w_valid  <= 1'b0;
            end

            // Host write of the address beats the post-handshake increment.
            if (wr_aw_addr)
                load_aw_addr <= axil.wdata[LOAD_ADDR_W-1:0];
            else if (aw_hs)
                load_aw_addr <= load_aw_addr + AW_STEP;

            if (wr_load_en)
                beat_count <= '0;
            else if (w_hs && (beat_count != 32'hFFFF_FFFF))
                beat_count <= beat_count + 32'd1;

            if (err_set)
                err <= 1'b1;
            else if (wr_err_clr)
                err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axil_cfg_loader.sv
// Directed testbench for axil_cfg_loader: table of register accesses with
// expected read data, followed by hand-written load-beat sequences.
module tb_axil_cfg_loader;
    localparam int LDW  = 512;
    localparam int LAW  = 15;
    localparam int MAXW = 20;
    localparam int NV   = 18;
    localparam logic [63:0] ID_WORD  = 64'hA0A1A2A3_DEADBEEF;
    localparam logic [63:0] BAD_WORD = 64'hDEADDEAD_DEADDEAD;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             enable;
    logic [63:0]      physical_address_base;
    logic             core_rst;
    logic             load_en;
    logic             load_aw_valid;
    logic             load_aw_ready;
    logic [LAW-1:0]   load_aw_addr;
    logic             load_w_valid;
    logic             load_w_ready;
    logic [LDW-1:0]   load_w_data;
    logic [LDW/8-1:0] load_w_strb;

    int checks = 0;
    int errors = 0;
    int w_hs_cnt = 0;

    always #5 clk = ~clk;

    axil_cfg_loader_if bus();

    axil_cfg_loader #(.LOAD_DATA_W(LDW), .LOAD_ADDR_W(LAW)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .axil                  (bus),
        .enable                (enable),
        .physical_address_base (physical_address_base),
        .core_rst              (core_rst),
        .load_en               (load_en),
        .load_aw_valid         (load_aw_valid),
        .load_aw_ready         (load_aw_ready),
        .load_aw_addr          (load_aw_addr),
        .load_w_valid          (load_w_valid),
        .load_w_ready          (load_w_ready),
        .load_w_data           (load_w_data),
        .load_w_strb           (load_w_strb)
    );

    always @(posedge clk) begin
        if (load_w_valid && load_w_ready) w_hs_cnt <= w_hs_cnt + 1;
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=no-handshake required=handshake", name);
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic axil_write(input logic [31:0] a, input logic [63:0] d,
                              input logic [7:0] s, input bit rel_aw);
        int n;
        bus.awvalid = 1'b1;
        bus.awaddr  = a;
        n = 0;
        while (!bus.awready && n < MAXW) begin @(posedge clk); #1; n++; end
        if (n >= MAXW) timeout_fail("awready");
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b1;
        bus.wdata   = d;
        bus.wstrb   = s;
        if (rel_aw) load_aw_ready = 1'b1;
        n = 0;
        while (!bus.wready && n < MAXW) begin @(posedge clk); #1; n++; end
        if (n >= MAXW) timeout_fail("wready");
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < MAXW) begin @(posedge clk); #1; n++; end
        if (n >= MAXW) timeout_fail("bvalid");
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d);
        axil_write(a, d, 8'hFF, 1'b0);
    endtask

    task automatic axil_read(input logic [31:0] a, output logic [63:0] d);
        int n;
        bus.arvalid = 1'b1;
        bus.araddr  = a;
        n = 0;
        while (!bus.arready && n < MAXW) begin @(posedge clk); #1; n++; end
        if (n >= MAXW) timeout_fail("arready");
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < MAXW) begin @(posedge clk); #1; n++; end
        if (n >= MAXW) timeout_fail("rvalid");
        d = bus.rdata;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [63:0] exp);
        logic [63:0] d;
        axil_read(a, d);
        check(name, d, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]    rd;
        logic [LDW-1:0] snap;
        int             hs0;

        vecs[0]  = '{wr: 1'b0, addr: 32'h00, data: 64'h0, exp: ID_WORD};
        vecs[1]  = '{wr: 1'b0, addr: 32'h18, data: 64'h0, exp: BAD_WORD};
        vecs[2]  = '{wr: 1'b1, addr: 32'h10, data: 64'hFFFF_FFFF_FFFF_FFFF, exp: 64'h0};
        vecs[3]  = '{wr: 1'b0, addr: 32'h10, data: 64'h0, exp: 64'h1};
        vecs[4]  = '{wr: 1'b1, addr: 32'h20, data: 64'h0123_4567_89AB_CDEF, exp: 64'h0};
        vecs[5]  = '{wr: 1'b0, addr: 32'h20, data: 64'h0, exp: 64'h0123_4567_89AB_CDEF};
        vecs[6]  = '{wr: 1'b1, addr: 32'h30, data: 64'h1, exp: 64'h0};
        vecs[7]  = '{wr: 1'b0, addr: 32'h30, data: 64'h0, exp: 64'h1};
        vecs[8]  = '{wr: 1'b1, addr: 32'h00, data: 64'h55, exp: 64'h0};
        vecs[9]  = '{wr: 1'b0, addr: 32'h00, data: 64'h0, exp: ID_WORD};
        vecs[10] = '{wr: 1'b1, addr: 32'h44, data: 64'h77, exp: 64'h0};
        vecs[11] = '{wr: 1'b0, addr: 32'h44, data: 64'h0, exp: BAD_WORD};
        vecs[12] = '{wr: 1'b1, addr: 32'h60, data: 64'h3, exp: 64'h0};
        vecs[13] = '{wr: 1'b0, addr: 32'h60, data: 64'h0, exp: 64'h3};
        vecs[14] = '{wr: 1'b1, addr: 32'hA0, data: 64'h1234, exp: 64'h0};
        vecs[15] = '{wr: 1'b0, addr: 32'hA0, data: 64'h0, exp: 64'h1234};
        vecs[16] = '{wr: 1'b1, addr: 32'h30, data: 64'h0, exp: 64'h0};
        vecs[17] = '{wr: 1'b0, addr: 32'h88, data: 64'h0, exp: 64'h0};

        bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0;
        bus.wstrb = '0; bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0;
        bus.rready = 1'b0;
        load_aw_ready = 1'b0;
        load_w_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_enable", 64'(enable), 64'h0);
        check("rst_aw_valid", 64'(load_aw_valid), 64'h0);
        check("rst_w_valid", 64'(load_w_valid), 64'h0);
        check("rst_aw_addr", 64'(load_aw_addr), 64'h0);
        check("rst_rdata", bus.rdata, 64'h0);
        check("rst_awready", 64'(bus.awready), 64'h1);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Register map table
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].data);
            end else begin
                axil_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), rd, vecs[i].exp);
            end
        end
        check("out_enable", 64'(enable), 64'h1);
        check("out_base", physical_address_base, 64'h0123_4567_89AB_CDEF);
        check("out_core_rst", 64'(core_rst), 64'h0);
        check("out_aw_addr", 64'(load_aw_addr), 64'h1234);
        check("out_strb", 64'(load_w_strb), 64'hFFFF_FFFF_FFFF_FFFF);

        // Full beat: eight lanes then commit, both readies high
        load_aw_ready = 1'b1;
        load_w_ready  = 1'b1;
        wr(32'h50, 64'h1);
        wr(32'hA0, 64'h100);
        wr(32'h60, 64'h0);
        for (int k = 0; k < 8; k++) wr(32'h70, 64'(k + 1));
        rd_check("lane_idx_wrap", 32'h60, 64'h0);
        hs0 = w_hs_cnt;
        wr(32'h80, 64'h0);
        check("beat_w_handshakes", 64'(w_hs_cnt - hs0), 64'h1);
        check("beat_aw_valid_clr", 64'(load_aw_valid), 64'h0);
        check("beat_aw_addr", 64'(load_aw_addr), 64'h140);
        for (int k = 0; k < 8; k++)
            check($sformatf("beat_lane%0d", k), load_w_data[k*64 +: 64], 64'(k + 1));
        rd_check("beat_status", 32'h88, 64'h0000_0001_0000_0000);

        // Partial strobe lane write
        axil_write(32'h70, 64'h1122_3344_5566_7788, 8'h0F, 1'b0);
        check("strb_lane0", load_w_data[63:0], 64'h0000_0000_5566_7788);

        // Stalled W channel: aw completes, w stays pending
        wr(32'h60, 64'h2);
        load_w_ready = 1'b0;
        wr(32'h80, 64'h0);
        repeat (5) begin @(posedge clk); #1; end
        check("stall_w_valid", 64'(load_w_valid), 64'h1);
        check("stall_aw_addr", 64'(load_aw_addr), 64'h180);
        snap = load_w_data;
        rd_check("stall_status", 32'h88, 64'h0000_0001_0000_0001);
        wr(32'h80, 64'h0);
        rd_check("stall_commit_err", 32'h88, 64'h0000_0001_0000_0005);
        wr(32'h70, 64'hAAAA_AAAA_AAAA_AAAA);
        wr(32'h60, 64'h5);
        check("stall_lane2_stable", load_w_data[191:128], snap[191:128]);
        check("stall_lane2_value", load_w_data[191:128], 64'h3);
        check("stall_lane0_stable", load_w_data[63:0], 64'h0000_0000_5566_7788);
        rd_check("stall_lane_idx_kept", 32'h60, 64'h2);
        load_w_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_w_released", 64'(load_w_valid), 64'h0);
        rd_check("stall_status_done", 32'h88, 64'h0000_0002_0000_0004);
        wr(32'h90, 64'h0);
        rd_check("err_cleared", 32'h88, 64'h0000_0002_0000_0000);

        // Commit with load_en=0
        wr(32'h50, 64'h0);
        check("load_en_off", 64'(load_en), 64'h0);
        wr(32'h80, 64'h0);
        check("off_aw_valid", 64'(load_aw_valid), 64'h0);
        check("off_w_valid", 64'(load_w_valid), 64'h0);
        rd_check("off_status", 32'h88, 64'h0000_0000_0000_0004);
        wr(32'h90, 64'h0);
        rd_check("off_err_clr", 32'h88, 64'h0);

        // Host 0xA0 write coinciding with an AW handshake
        wr(32'h50, 64'h1);
        load_aw_ready = 1'b0;
        wr(32'h80, 64'h0);
        check("prio_aw_pending", 64'(load_aw_valid), 64'h1);
        check("prio_w_done", 64'(load_w_valid), 64'h0);
        axil_write(32'hA0, 64'h200, 8'hFF, 1'b1);
        check("prio_aw_addr", 64'(load_aw_addr), 64'h200);
        check("prio_aw_valid_clr", 64'(load_aw_valid), 64'h0);

        // Address wrap
        wr(32'hA0, 64'h7FC0);
        wr(32'h80, 64'h0);
        check("wrap_aw_addr", 64'(load_aw_addr), 64'h0);
        rd_check("wrap_status", 32'h88, 64'h0000_0002_0000_0000);

        // Reset during WRITE_B with a pending beat
        wr(32'hA0, 64'h40);
        load_aw_ready = 1'b0;
        load_w_ready  = 1'b0;
        wr(32'h80, 64'h0);
        check("pre_rst_aw_valid", 64'(load_aw_valid), 64'h1);
        bus.awvalid = 1'b1; bus.awaddr = 32'h10;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b1; bus.wdata = 64'h1; bus.wstrb = 8'hFF;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        check("pre_rst_bvalid", 64'(bus.bvalid), 64'h1);
        rstn = 1'b0;
        #1;
        check("arst_enable", 64'(enable), 64'h0);
        check("arst_base", physical_address_base, 64'h0);
        check("arst_load_en", 64'(load_en), 64'h0);
        check("arst_aw_valid", 64'(load_aw_valid), 64'h0);
        check("arst_w_valid", 64'(load_w_valid), 64'h0);
        check("arst_aw_addr", 64'(load_aw_addr), 64'h0);
        check("arst_wdata_any", 64'(|load_w_data), 64'h0);
        check("arst_bvalid", 64'(bus.bvalid), 64'h0);
        check("arst_rdata", bus.rdata, 64'h0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        load_aw_ready = 1'b1;
        load_w_ready  = 1'b1;
        rd_check("post_rst_id", 32'h00, ID_WORD);
        check("post_rst_w_valid", 64'(load_w_valid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
